// File: rtl/stage_tl_pkg.sv
// Shared types and constants for the TL pipeline stage and its DTLB.
package stage_tl_pkg;

  localparam int PAGE_BITS = 12;
  localparam int PADDR_W   = 20;
  localparam int VPN_W     = 32 - PAGE_BITS;
  localparam int PPN_W     = PADDR_W - PAGE_BITS;

  typedef logic [31:0] word_t;
  typedef logic [31:0] vptr_t;
  typedef logic [4:0]  regid_t;
  typedef logic [1:0]  threadid_t;

  typedef enum logic [1:0] {
    TLBW_OFF  = 2'd0,
    TLBW_ITLB = 2'd1,
    TLBW_DTLB = 2'd2
  } tlbwrite_t;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } dtlb_entry_t;

  // Virtual page number of a 32-bit address.
  function automatic logic [VPN_W-1:0] vpn_of(input word_t addr);
    return addr[31:PAGE_BITS];
  endfunction

endpackage

// File: rtl/stage_tl_dtlb_cam.sv
// Fully-associative DTLB: entry array, lookup match, install slot choice
// (matching entry, else lowest free entry, else round-robin pointer).
module dtlb_cam
  import stage_tl_pkg::*;
#(
  parameter int DTLB_ENTRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VPN_W-1:0] vpn,
  input  logic             wr_en,
  input  logic [PPN_W-1:0] wr_ppn,
  output logic             hit,
  output logic [PPN_W-1:0] ppn
);

  localparam int IDX_W = (DTLB_ENTRIES > 1) ? $clog2(DTLB_ENTRIES) : 1;

  dtlb_entry_t      entry_r [DTLB_ENTRIES];
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] hit_idx_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [IDX_W-1:0] slot_s;
  logic             hit_s;
  logic             free_s;

  // Match the looked-up VPN and find the lowest-index free entry.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = 0; i < DTLB_ENTRIES; i++) begin
      if (entry_r[i].valid && (entry_r[i].vpn == vpn)) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
    // Descending scan so the lowest free index is the one kept.
    for (int i = DTLB_ENTRIES - 1; i >= 0; i--) begin
      if (!entry_r[i].valid) begin
        free_s     = 1'b1;
        free_idx_s = IDX_W'(i);
      end else begin
        free_s     = free_s;
      end
    end
    if (hit_s) begin
      slot_s = hit_idx_s;
    end else if (free_s) begin
      slot_s = free_idx_s;
    end else begin
      slot_s = ptr_r;
    end
  end

  // Translation result; a miss yields a zero PPN so the output is deterministic.
  always_comb begin
    hit = hit_s;
    if (hit_s) begin
      ppn = entry_r[hit_idx_s].ppn;
    end else begin
      ppn = '0;
    end
  end

  // Install entries and advance the replacement pointer when it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DTLB_ENTRIES; i++) begin
        entry_r[i] <= '0;
      end
      ptr_r <= '0;
    end else if (wr_en) begin
      entry_r[slot_s] <= '{valid: 1'b1, vpn: vpn, ppn: wr_ppn};
      if (!hit_s && !free_s) begin
        ptr_r <= ptr_r + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/stage_tl.sv
// TL pipeline stage: DTLB translation, DTLB install, redirect resolution and
// one registered level toward the data-cache stage with downstream stall.
// Optional hit/miss counters are built when DTLB_STATS_EN is defined.
module stage_tl
  import stage_tl_pkg::*;
#(
  parameter int DTLB_ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  threadid_t          tl_thread,
  input  logic               tl_isvalid,
  input  logic               tl_itlb_miss,
  input  vptr_t              tl_pc,
  input  word_t              tl_data,
  input  word_t              tl_mul,
  input  word_t              tl_r2,
  input  regid_t             tl_dst,
  input  logic               tl_isequal,
  input  logic               tl_flag_mem,
  input  logic               tl_flag_store,
  input  logic               tl_flag_isbyte,
  input  logic               tl_flag_mul,
  input  logic               tl_flag_reg,
  input  logic               tl_flag_jump,
  input  logic               tl_flag_branch,
  input  logic               tl_flag_iret,
  input  tlbwrite_t          tl_flag_tlbwrite,
  input  word_t              tl_rm4,
  input  logic               supervisor,
  input  logic               dc_stall,
  output threadid_t          dc_thread,
  output logic               dc_isvalid,
  output logic               dc_itlb_miss,
  output vptr_t              dc_pc,
  output regid_t             dc_dst,
  output word_t              dc_r2,
  output word_t              dc_rm4,
  output logic               dc_flag_mem,
  output logic               dc_flag_store,
  output logic               dc_flag_isbyte,
  output logic               dc_flag_mul,
  output logic               dc_flag_reg,
  output logic               dc_flag_jump,
  output logic               dc_flag_branch,
  output logic               dc_flag_iret,
  output word_t              dc_data,
  output logic [PADDR_W-1:0] dc_paddr,
  output logic               dc_dtlb_miss,
  output logic               dc_redirect,
  output vptr_t              dc_target,
  output logic               dc_itlb_wr,
  output logic               tl_stall
`ifdef DTLB_STATS_EN
  ,
  output logic [15:0]        stat_hits,
  output logic [15:0]        stat_misses
`endif
);

  logic               cam_hit_s;
  logic [PPN_W-1:0]   cam_ppn_s;
  logic               install_s;
  logic               miss_s;
  logic               redirect_s;
  logic [PADDR_W-1:0] paddr_s;

  assign tl_stall = dc_stall;

  dtlb_cam #(.DTLB_ENTRIES(DTLB_ENTRIES)) u_dtlb (
    .clk    (clk),
    .rst    (rst),
    .vpn    (vpn_of(tl_data)),
    .wr_en  (install_s),
    .wr_ppn (tl_r2[PPN_W-1:0]),
    .hit    (cam_hit_s),
    .ppn    (cam_ppn_s)
  );

  // Translation, miss detection, install enable and redirect decision.
  always_comb begin
    install_s  = tl_isvalid && (tl_flag_tlbwrite == TLBW_DTLB) && !dc_stall;
    miss_s     = tl_isvalid && tl_flag_mem && !supervisor && !cam_hit_s && !tl_itlb_miss;
    redirect_s = tl_isvalid && !tl_itlb_miss && (tl_flag_jump || (tl_flag_branch && tl_isequal));
    if (supervisor) begin
      paddr_s = tl_data[PADDR_W-1:0];
    end else begin
      paddr_s = {cam_ppn_s, tl_data[PAGE_BITS-1:0]};
    end
  end

  // Pipeline register toward the data-cache stage; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_thread      <= '0;
      dc_isvalid     <= 1'b0;
      dc_itlb_miss   <= 1'b0;
      dc_pc          <= '0;
      dc_dst         <= '0;
      dc_r2          <= '0;
      dc_rm4         <= '0;
      dc_flag_mem    <= 1'b0;
      dc_flag_store  <= 1'b0;
      dc_flag_isbyte <= 1'b0;
      dc_flag_mul    <= 1'b0;
      dc_flag_reg    <= 1'b0;
      dc_flag_jump   <= 1'b0;
      dc_flag_branch <= 1'b0;
      dc_flag_iret   <= 1'b0;
      dc_data        <= '0;
      dc_paddr       <= '0;
      dc_dtlb_miss   <= 1'b0;
      dc_redirect    <= 1'b0;
      dc_target      <= '0;
      dc_itlb_wr     <= 1'b0;
    end else if (!dc_stall) begin
      dc_thread      <= tl_thread;
      dc_isvalid     <= tl_isvalid;
      dc_itlb_miss   <= tl_itlb_miss;
      dc_pc          <= tl_pc;
      dc_dst         <= tl_dst;
      dc_r2          <= tl_r2;
      dc_rm4         <= tl_rm4;
      dc_flag_mem    <= tl_flag_mem;
      dc_flag_store  <= tl_flag_store && !miss_s;
      dc_flag_isbyte <= tl_flag_isbyte;
      dc_flag_mul    <= tl_flag_mul;
      dc_flag_reg    <= tl_flag_reg && !miss_s;
      dc_flag_jump   <= tl_flag_jump;
      dc_flag_branch <= tl_flag_branch;
      dc_flag_iret   <= tl_flag_iret;
      dc_data        <= tl_flag_mul ? tl_mul : tl_data;
      dc_paddr       <= paddr_s;
      dc_dtlb_miss   <= miss_s;
      dc_redirect    <= redirect_s;
      dc_target      <= tl_data;
      dc_itlb_wr     <= tl_isvalid && (tl_flag_tlbwrite == TLBW_ITLB);
    end
  end

`ifdef DTLB_STATS_EN
  // Saturating hit/miss counters over non-stalled valid user-mode accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= 16'd0;
      stat_misses <= 16'd0;
    end else if (tl_isvalid && tl_flag_mem && !supervisor && !dc_stall) begin
      if (cam_hit_s && (stat_hits != 16'hFFFF)) begin
        stat_hits <= stat_hits + 16'd1;
      end
      if (miss_s && (stat_misses != 16'hFFFF)) begin
        stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage_tl.sv
// Directed bench for stage_tl with a behavioural DTLB/pipeline model.
module tb_stage_tl;
  import stage_tl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  threadid_t tl_thread;
  logic tl_isvalid, tl_itlb_miss, tl_isequal;
  vptr_t tl_pc;
  word_t tl_data, tl_mul, tl_r2, tl_rm4;
  regid_t tl_dst;
  logic tl_flag_mem, tl_flag_store, tl_flag_isbyte, tl_flag_mul, tl_flag_reg;
  logic tl_flag_jump, tl_flag_branch, tl_flag_iret;
  tlbwrite_t tl_flag_tlbwrite;
  logic supervisor, dc_stall;

  threadid_t dc_thread;
  logic dc_isvalid, dc_itlb_miss;
  vptr_t dc_pc, dc_target;
  regid_t dc_dst;
  word_t dc_r2, dc_rm4, dc_data;
  logic dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_mul, dc_flag_reg;
  logic dc_flag_jump, dc_flag_branch, dc_flag_iret;
  logic [19:0] dc_paddr;
  logic dc_dtlb_miss, dc_redirect, dc_itlb_wr, tl_stall;
`ifdef DTLB_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  stage_tl #(.DTLB_ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .tl_thread(tl_thread), .tl_isvalid(tl_isvalid),
    .tl_itlb_miss(tl_itlb_miss), .tl_pc(tl_pc), .tl_data(tl_data), .tl_mul(tl_mul),
    .tl_r2(tl_r2), .tl_dst(tl_dst), .tl_isequal(tl_isequal),
    .tl_flag_mem(tl_flag_mem), .tl_flag_store(tl_flag_store), .tl_flag_isbyte(tl_flag_isbyte),
    .tl_flag_mul(tl_flag_mul), .tl_flag_reg(tl_flag_reg), .tl_flag_jump(tl_flag_jump),
    .tl_flag_branch(tl_flag_branch), .tl_flag_iret(tl_flag_iret),
    .tl_flag_tlbwrite(tl_flag_tlbwrite), .tl_rm4(tl_rm4), .supervisor(supervisor),
    .dc_stall(dc_stall), .dc_thread(dc_thread), .dc_isvalid(dc_isvalid),
    .dc_itlb_miss(dc_itlb_miss), .dc_pc(dc_pc), .dc_dst(dc_dst), .dc_r2(dc_r2),
    .dc_rm4(dc_rm4), .dc_flag_mem(dc_flag_mem), .dc_flag_store(dc_flag_store),
    .dc_flag_isbyte(dc_flag_isbyte), .dc_flag_mul(dc_flag_mul), .dc_flag_reg(dc_flag_reg),
    .dc_flag_jump(dc_flag_jump), .dc_flag_branch(dc_flag_branch), .dc_flag_iret(dc_flag_iret),
    .dc_data(dc_data), .dc_paddr(dc_paddr), .dc_dtlb_miss(dc_dtlb_miss),
    .dc_redirect(dc_redirect), .dc_target(dc_target), .dc_itlb_wr(dc_itlb_wr),
    .tl_stall(tl_stall)
`ifdef DTLB_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The DTLB as a small table of (valid, vpn, ppn) plus a round-robin pointer.
  logic        m_valid [4];
  logic [19:0] m_vpn   [4];
  logic [7:0]  m_ppn   [4];
  int          m_ptr;

  // Expected registered outputs.
  logic        e_isvalid, e_miss, e_redirect, e_itlb_wr, e_itlb_miss;
  logic [19:0] e_paddr;
  logic [31:0] e_data, e_target, e_pc, e_r2, e_rm4;
  logic [4:0]  e_dst;
  logic [1:0]  e_thread;
  logic [7:0]  e_flags;

  always begin
    logic hit, miss, do_inst, do_clr;
    logic [7:0] ppn;
    logic [19:0] vpn;
    int slot;
    @(negedge clk);
    do_inst = 1'b0;
    do_clr  = 1'b0;
    vpn     = tl_data[31:12];
    if (rst) begin
      do_clr = 1'b1;
      {e_isvalid, e_miss, e_redirect, e_itlb_wr, e_itlb_miss} = '0;
      e_paddr = '0; e_data = '0; e_target = '0; e_pc = '0; e_r2 = '0; e_rm4 = '0;
      e_dst = '0; e_thread = '0; e_flags = '0;
    end else if (!dc_stall) begin
      hit = 1'b0;
      ppn = 8'd0;
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && m_vpn[i] == vpn) begin hit = 1'b1; ppn = m_ppn[i]; end
      miss = tl_isvalid && tl_flag_mem && !supervisor && !hit && !tl_itlb_miss;
      e_miss      = miss;
      e_isvalid   = tl_isvalid;
      e_paddr     = supervisor ? tl_data[19:0] : {ppn, tl_data[11:0]};
      e_redirect  = tl_isvalid && !tl_itlb_miss && (tl_flag_jump || (tl_flag_branch && tl_isequal));
      e_itlb_wr   = tl_isvalid && tl_flag_tlbwrite == TLBW_ITLB;
      e_itlb_miss = tl_itlb_miss;
      e_data      = tl_flag_mul ? tl_mul : tl_data;
      e_target    = tl_data;
      e_pc = tl_pc; e_r2 = tl_r2; e_rm4 = tl_rm4; e_dst = tl_dst; e_thread = tl_thread;
      e_flags = {tl_flag_mem, tl_flag_store && !miss, tl_flag_isbyte, tl_flag_mul,
                 tl_flag_reg && !miss, tl_flag_jump, tl_flag_branch, tl_flag_iret};
      do_inst = tl_isvalid && tl_flag_tlbwrite == TLBW_DTLB;
    end
    chk("tl_stall", {63'd0, tl_stall}, {63'd0, dc_stall});
    @(posedge clk);
    #1;
    if (do_clr) begin
      for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_vpn[i] = '0; m_ppn[i] = '0; end
      m_ptr = 0;
    end else if (do_inst) begin
      slot = -1;
      for (int i = 0; i < 4; i++) if (slot < 0 && m_valid[i] && m_vpn[i] == vpn) slot = i;
      for (int i = 0; i < 4; i++) if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) begin slot = m_ptr; m_ptr = (m_ptr + 1) % 4; end
      m_valid[slot] = 1'b1; m_vpn[slot] = vpn; m_ppn[slot] = tl_r2[7:0];
    end
    chk("isvalid",   {63'd0, dc_isvalid},   {63'd0, e_isvalid});
    chk("dtlb_miss", {63'd0, dc_dtlb_miss}, {63'd0, e_miss});
    chk("redirect",  {63'd0, dc_redirect},  {63'd0, e_redirect});
    chk("itlb_wr",   {63'd0, dc_itlb_wr},   {63'd0, e_itlb_wr});
    chk("itlb_miss", {63'd0, dc_itlb_miss}, {63'd0, e_itlb_miss});
    chk("paddr",     {44'd0, dc_paddr},     {44'd0, e_paddr});
    chk("data",      {32'd0, dc_data},      {32'd0, e_data});
    chk("target",    {32'd0, dc_target},    {32'd0, e_target});
    chk("pc_r2",     {dc_pc, dc_r2},        {e_pc, e_r2});
    chk("rm4",       {32'd0, dc_rm4},       {32'd0, e_rm4});
    chk("dst_thr",   {57'd0, dc_dst, dc_thread}, {57'd0, e_dst, e_thread});
    chk("flags", {56'd0, dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_mul,
                  dc_flag_reg, dc_flag_jump, dc_flag_branch, dc_flag_iret}, {56'd0, e_flags});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tl_thread = 2'd0; tl_isvalid = 1'b0; tl_itlb_miss = 1'b0; tl_pc = 32'd0;
    tl_data = 32'd0; tl_mul = 32'd0; tl_r2 = 32'd0; tl_dst = 5'd0; tl_isequal = 1'b0;
    tl_flag_mem = 1'b0; tl_flag_store = 1'b0; tl_flag_isbyte = 1'b0; tl_flag_mul = 1'b0;
    tl_flag_reg = 1'b0; tl_flag_jump = 1'b0; tl_flag_branch = 1'b0; tl_flag_iret = 1'b0;
    tl_flag_tlbwrite = TLBW_OFF; tl_rm4 = 32'd0; supervisor = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr);
    idle();
    tl_isvalid = 1'b1; tl_flag_mem = 1'b1; tl_flag_reg = 1'b1; tl_data = addr;
    tl_pc = addr ^ 32'h0000_1111; tl_dst = 5'd7; tl_thread = 2'd2; tl_rm4 = 32'h0000_ABCD;
    tl_mul = 32'hDEAD_0000;
  endtask

  task automatic inst(input logic [31:0] va, input logic [31:0] ppn);
    idle();
    tl_isvalid = 1'b1; tl_flag_tlbwrite = TLBW_DTLB; tl_data = va; tl_r2 = ppn;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); cyc(); cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dc_stall = 1'b0; idle();
    cyc(); cyc();
    chk("rst_isvalid", {63'd0, dc_isvalid}, 64'd0);
    chk("rst_miss",    {63'd0, dc_dtlb_miss}, 64'd0);
    chk("rst_redir",   {63'd0, dc_redirect}, 64'd0);
    chk("rst_paddr",   {44'd0, dc_paddr}, 64'd0);
    rst = 1'b0;

    // Empty DTLB, user load -> miss carried as a valid exception.
    load(32'h0000_3ABC); cyc();
    chk("miss1_miss",  {63'd0, dc_dtlb_miss}, 64'd1);
    chk("miss1_valid", {63'd0, dc_isvalid}, 64'd1);
    chk("miss1_reg",   {63'd0, dc_flag_reg}, 64'd0);

    // Install then hit.
    inst(32'h0000_3000, 32'h0000_005A); cyc();
    load(32'h0000_3ABC); cyc();
    chk("hit_paddr", {44'd0, dc_paddr}, 64'h5AABC);
    chk("hit_miss",  {63'd0, dc_dtlb_miss}, 64'd0);

    // Five installs into four entries: VPN 1 is evicted.
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      inst(32'(v) << 12, 32'h10 + 32'(v)); cyc();
    end
    load(32'h0000_1000); cyc();
    chk("evict_miss", {63'd0, dc_dtlb_miss}, 64'd1);
    load(32'h0000_5234); cyc();
    chk("vpn5_paddr", {44'd0, dc_paddr}, 64'h15234);
    // Reinstall VPN 2 in place; VPNs 3,4,5 must all survive.
    inst(32'h0000_2000, 32'h0000_0077); cyc();
    load(32'h0000_2ABC); cyc();
    chk("vpn2_paddr", {44'd0, dc_paddr}, 64'h77ABC);
    for (int v = 3; v <= 5; v++) begin
      load(32'(v) << 12); cyc();
      chk("nodup_miss", {63'd0, dc_dtlb_miss}, 64'd0);
      chk("nodup_paddr", {44'd0, dc_paddr}, {44'd0, 8'(32'h10 + 32'(v)), 12'h000});
    end

    // Supervisor bypass with an empty DTLB.
    do_reset();
    load(32'hFFF1_2345); supervisor = 1'b1; cyc();
    chk("sup_paddr", {44'd0, dc_paddr}, 64'h12345);
    chk("sup_miss",  {63'd0, dc_dtlb_miss}, 64'd0);

    // Taken branch, then the same with isvalid low.
    idle(); tl_isvalid = 1'b1; tl_flag_branch = 1'b1; tl_isequal = 1'b1; tl_data = 32'h400; cyc();
    chk("br_redir",  {63'd0, dc_redirect}, 64'd1);
    chk("br_target", {32'd0, dc_target}, 64'h400);
    tl_isvalid = 1'b0; cyc();
    chk("br_inval",  {63'd0, dc_redirect}, 64'd0);

    // ITLB install request for one cycle.
    idle(); tl_isvalid = 1'b1; tl_flag_tlbwrite = TLBW_ITLB; tl_data = 32'h0000_7000; cyc();
    chk("itlb_wr1", {63'd0, dc_itlb_wr}, 64'd1);
    idle(); cyc();
    chk("itlb_wr0", {63'd0, dc_itlb_wr}, 64'd0);

    // Install held by a three-cycle stall, completing on release.
    inst(32'h0000_9000, 32'h0000_0033); dc_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_valid", {63'd0, dc_isvalid}, 64'd0);
      chk("stall_data",  {32'd0, dc_data}, 64'd0);
    end
    dc_stall = 1'b0; cyc();
    chk("rel_valid", {63'd0, dc_isvalid}, 64'd1);
    load(32'h0000_9123); cyc();
    chk("stall_inst_paddr", {44'd0, dc_paddr}, 64'h33123);
    chk("stall_inst_miss",  {63'd0, dc_dtlb_miss}, 64'd0);

    idle(); cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
